mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits downstream of the EX/MEM pipeline register and consumes its outputs.
- Turns load/store control into a req/ack data-memory transaction and stalls upstream while the transaction is outstanding.
- Registers the writeback bundle (regWrite, destination register, write data) for the WB stage.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- DATA_W, 32, datapath and memory word width
- REG_W, 5, register-file address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ALUResultIn  in  DATA_W  ALU result / effective memory address
- writeDataIn  in  DATA_W  store data (rt value)
- dataForWRIn  in  REG_W  destination register
- newPCIn  in  DATA_W  link value for JAL
- regWriteIn, memReadIn, memWriteIn, memToRegIn, JALIn  in  1 each  control from EX/MEM
- memReq  out  1  memory request, held until memAck
- memWe  out  1  1 = write, 0 = read
- memAddr  out  DATA_W  word address, byte offset [1:0] forced 0
- memWData  out  DATA_W  store data
- memAck  in  1  one-cycle completion strobe
- memRData  in  DATA_W  load data, valid with memAck
- stall  out  1  combinational hold request to PC/IF_ID/ID_EX/EX_MEM
- regWriteOut  out  1  WB write enable
- writeRegOut  out  REG_W  WB destination
- writeDataOut  out  DATA_W  WB data

Behaviour:
- Reset is synchronous, active-high, and clocked by clk. On reset:
  - state=IDLE, memReq=0, memWe=0, memAddr=0, memWData=0.
  - regWriteOut=0, writeRegOut=0, writeDataOut=0.
- FSM states: IDLE, ACCESS.
- IDLE, no memory op (memReadIn=memWriteIn=0):
  - stall=0.
  - Each edge loads the WB registers: regWriteOut=regWriteIn & (dataForWRIn!=0); writeRegOut=dataForWRIn.
  - writeDataOut=JALIn ? newPCIn : ALUResultIn.
- IDLE, memory op present:
  - stall=1 in the same cycle.
  - At the edge: latch memAddr={ALUResultIn[DATA_W-1:2],2'b00}, memWData=writeDataIn, memWe=memWriteIn.
  - Also latch regWrite, destination register and memToReg; set memReq=1; go to ACCESS.
  - WB registers load a bubble (regWriteOut=0).
- ACCESS:
  - memReq, memWe, memAddr and memWData held stable.
  - stall = ~memAck.
  - While memAck=0, WB registers hold the bubble (regWriteOut=0).
- ACCESS with memAck=1, at the edge:
  - memReq=0; go to IDLE.
  - WB registers load the latched instruction. writeDataOut = memRData for loads with memToReg=1, otherwise the latched ALU result. regWriteOut = latched regWrite & (dest!=0).
  - Because stall=0 in the ack cycle, EX/MEM advances on the same edge.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: stall asserted for N+1 cycles, where N = cycles from memReq rising to memAck (minimum N=1, so minimum 2 stall cycles).
- memReadIn=memWriteIn=1 together is a protocol violation: treated as a write, no regWrite.
- memAck while in IDLE is ignored.
- Reset asserted during ACCESS: memReq drops at that edge, the transaction is abandoned, and a late memAck is ignored.
- Register 0 is never written (regWriteOut forced 0 when destination==0).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op with ALUResultIn[1:0]!=0 issues no memReq and no stall.
  - Output alignErr (1 bit, exists only when the macro is defined) pulses 1 for one cycle, registered with the WB bundle.
  - regWriteOut=0 for that instruction.
- Undefined: no alignErr port; the low address bits are silently cleared and the access proceeds.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_W constants.
  - mem_state_t enum {IDLE, ACCESS}.
  - wb_sel_t enum {WB_ALU, WB_MEM, WB_LINK} for the writeback mux select.
- Sub-module mem_handshake_fsm owns state, memReq/memWe/memAddr/memWData and stall generation.
- The top level holds the WB register bundle and the writeback mux.

Test Plan:
- Reset high for 2 cycles mid-ACCESS (memReq=1) -> next cycle memReq=0, regWriteOut=0, writeDataOut=0; a memAck one cycle later is ignored.
- ALU op, ALUResultIn=0x0000_0010, dest=8, regWrite=1 -> 1 cycle later regWriteOut=1, writeRegOut=8, writeDataOut=0x10, stall never 1.
- Load, addr=0x0000_0104, dest=9, memAck 3 cycles after memReq, memRData=0xDEAD_BEEF:
  - memAddr=0x104 stable throughout.
  - stall=1 for 4 cycles.
  - After the ack edge: regWriteOut=1, writeRegOut=9, writeDataOut=0xDEAD_BEEF, for exactly one cycle.
- Store, addr=0x200, data=0x1234_5678, immediate ack -> memWe=1, memWData=0x1234_5678, stall 2 cycles, regWriteOut stays 0.
- JAL with newPCIn=0x0040_0008, dest=31 -> writeDataOut=0x0040_0008, writeRegOut=31; ALU op with dest=0, regWrite=1 -> regWriteOut=0.
- With MEM_ALIGN_CHECK_EN, load addr=0x0000_0102 -> memReq stays 0, stall=0, alignErr=1 for one cycle, regWriteOut=0. Without the macro -> memAddr=0x0000_0100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline MEM stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake: owns the request registers and the
// upstream stall. start_o marks the cycle an access is issued, done_o the
// cycle its acknowledge arrives.
module mem_handshake_fsm #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid_i,
    input  logic              op_write_i,
    input  logic [DATA_W-1:2] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              stall_o,
    output logic              start_o,
    output logic              done_o
);
    import mips_pkg::*;

    mem_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Next state: capture the request on issue, hold it until acknowledged.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_o = 1'b0;
        start_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    stall_o = 1'b1;
                    start_o = 1'b1;
                    we_d    = op_write_i;
                    addr_d  = {addr_i, 2'b00};
                    wdata_d = wdata_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // The ack cycle releases the pipeline so EX/MEM advances on that edge.
                stall_o = ~mem_ack_i;
                if (mem_ack_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req_o   = (state_q == ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues data-memory accesses, stalls upstream while one is
// outstanding and registers the writeback bundle for WB.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned memory ops are dropped and
// reported on alignErr instead of having their low address bits cleared.
module mem_access_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [DATA_W-1:0] writeDataIn,
    input  logic [REG_W-1:0]  dataForWRIn,
    input  logic [DATA_W-1:0] newPCIn,
    input  logic              regWriteIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    input  logic              memToRegIn,
    input  logic              JALIn,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              stall,
    output logic              regWriteOut,
    output logic [REG_W-1:0]  writeRegOut,
    output logic [DATA_W-1:0] writeDataOut
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              alignErr
`endif
);
    import mips_pkg::*;

    logic mem_op, misaligned, op_valid, start, done;

    // Instruction latched at issue, retired into WB when the ack arrives.
    logic              pend_rw_q, pend_rw_d;
    logic [REG_W-1:0]  pend_rd_q, pend_rd_d;
    logic              pend_m2r_q, pend_m2r_d;
    logic [DATA_W-1:0] pend_alu_q, pend_alu_d;

    // Writeback bundle.
    logic              wb_rw_q, wb_rw_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              align_q, align_d;

    wb_sel_t           wb_sel;
    logic [DATA_W-1:0] wb_alu;
    logic              wb_load;

    function automatic logic [DATA_W-1:0] wb_mux(input wb_sel_t sel,
                                                 input logic [DATA_W-1:0] alu,
                                                 input logic [DATA_W-1:0] mem,
                                                 input logic [DATA_W-1:0] link);
        case (sel)
            WB_MEM:  return mem;
            WB_LINK: return link;
            default: return alu;
        endcase
    endfunction

    assign mem_op = memReadIn | memWriteIn;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (ALUResultIn[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign op_valid = mem_op & ~misaligned;

    mem_handshake_fsm #(
        .DATA_W (DATA_W)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .op_valid_i  (op_valid),
        .op_write_i  (memWriteIn),
        .addr_i      (ALUResultIn[DATA_W-1:2]),
        .wdata_i     (writeDataIn),
        .mem_ack_i   (memAck),
        .mem_req_o   (memReq),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWData),
        .stall_o     (stall),
        .start_o     (start),
        .done_o      (done)
    );

    // WB bundle next state: retire an acked access, insert a bubble while
    // one is in flight, otherwise pass the incoming instruction through.
    always_comb begin
        pend_rw_d  = pend_rw_q;
        pend_rd_d  = pend_rd_q;
        pend_m2r_d = pend_m2r_q;
        pend_alu_d = pend_alu_q;
        wb_rw_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        align_d    = 1'b0;
        wb_sel     = WB_ALU;
        wb_alu     = ALUResultIn;
        wb_load    = 1'b0;
        if (done) begin
            wb_rw_d = pend_rw_q & (pend_rd_q != '0);
            wb_rd_d = pend_rd_q;
            wb_alu  = pend_alu_q;
            wb_sel  = (pend_m2r_q & ~memWe) ? WB_MEM : WB_ALU;
            wb_load = 1'b1;
        end else if (start) begin
            // Read and write together is treated as a write with no writeback.
            pend_rw_d  = regWriteIn & ~(memReadIn & memWriteIn);
            pend_rd_d  = dataForWRIn;
            pend_m2r_d = memToRegIn;
            pend_alu_d = ALUResultIn;
        end else if (!memReq) begin
            wb_rw_d = regWriteIn & (dataForWRIn != '0) & ~misaligned;
            wb_rd_d = dataForWRIn;
            wb_sel  = JALIn ? WB_LINK : WB_ALU;
            wb_load = 1'b1;
            align_d = misaligned;
        end
        if (wb_load) begin
            wb_data_d = wb_mux(wb_sel, wb_alu, memRData, newPCIn);
        end
    end

    // Pending-instruction and WB bundle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rw_q  <= 1'b0;
            pend_rd_q  <= '0;
            pend_m2r_q <= 1'b0;
            pend_alu_q <= '0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            align_q    <= 1'b0;
        end else begin
            pend_rw_q  <= pend_rw_d;
            pend_rd_q  <= pend_rd_d;
            pend_m2r_q <= pend_m2r_d;
            pend_alu_q <= pend_alu_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            align_q    <= align_d;
        end
    end

    assign regWriteOut  = wb_rw_q;
    assign writeRegOut  = wb_rd_q;
    assign writeDataOut = wb_data_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign alignErr = align_q;
`else
    logic unused_align;
    assign unused_align = align_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage. Build with or without
// MEM_ALIGN_CHECK_EN to match the RTL configuration.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultIn, writeDataIn, newPCIn;
    logic [4:0]  dataForWRIn;
    logic        regWriteIn, memReadIn, memWriteIn, memToRegIn, JALIn;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic        memAck;
    logic [31:0] memRData;
    logic        stall;
    logic        regWriteOut;
    logic [4:0]  writeRegOut;
    logic [31:0] writeDataOut;
`ifdef MEM_ALIGN_CHECK_EN
    logic        alignErr;
`endif

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    mem_access_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUResultIn  (ALUResultIn),
        .writeDataIn  (writeDataIn),
        .dataForWRIn  (dataForWRIn),
        .newPCIn      (newPCIn),
        .regWriteIn   (regWriteIn),
        .memReadIn    (memReadIn),
        .memWriteIn   (memWriteIn),
        .memToRegIn   (memToRegIn),
        .JALIn        (JALIn),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWData     (memWData),
        .memAck       (memAck),
        .memRData     (memRData),
        .stall        (stall),
        .regWriteOut  (regWriteOut),
        .writeRegOut  (writeRegOut),
        .writeDataOut (writeDataOut)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .alignErr     (alignErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [31:0] npc,
                             input logic rw, input logic mr, input logic mw,
                             input logic m2r, input logic jal);
        ALUResultIn = alu;
        writeDataIn = wd;
        dataForWRIn = rd;
        newPCIn     = npc;
        regWriteIn  = rw;
        memReadIn   = mr;
        memWriteIn  = mw;
        memToRegIn  = m2r;
        JALIn       = jal;
    endtask

    task automatic nop();
        set_instr(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic rw, input logic [4:0] rd, input logic [31:0] data);
        wb_t e;
        e.rw = rw;
        e.rd = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // An empty scoreboard yields an all-X expectation, which never matches.
    task automatic pop_exp(output wb_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
    endtask

    // Memory responder: acks n+1 cycles into the request (n = cycles from
    // memReq rising to memAck). Returns observations of the transaction and
    // leaves time at the negedge of the ack cycle.
    task automatic mem_txn(input int n, input logic [31:0] rdata,
                           output int stalls, output logic [31:0] addr0,
                           output logic we0, output logic [31:0] wd0,
                           output bit moved, output bit bubble_bad, output bit timeout);
        int age;
        bit seen;
        age = 0;
        seen = 0;
        stalls = 0;
        moved = 0;
        bubble_bad = 0;
        timeout = 1;
        addr0 = 'x;
        we0 = 1'bx;
        wd0 = 'x;
        memAck = 1'b0;
        memRData = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (memReq === 1'b1) begin
                if (!seen) begin
                    addr0 = memAddr;
                    we0 = memWe;
                    wd0 = memWData;
                    seen = 1;
                end else if (memAddr !== addr0 || memWData !== wd0 || memWe !== we0) begin
                    moved = 1;
                end
                if (regWriteOut !== 1'b0) bubble_bad = 1;
            end
            if (stall !== 1'b1) begin
                timeout = 0;
                break;
            end
            stalls++;
            cyc();
            if (memReq === 1'b1) age++;
            memAck = (age == n + 1);
            memRData = memAck ? rdata : 32'h0;
        end
    endtask

    task automatic test_reset();
        wb_t e;
        reset = 1'b1;
        nop();
        memAck = 1'b0;
        memRData = 32'h0;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({memReq, memWe, memAddr, memWData} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h, want all 0", memReq, memWe, memAddr, memWData);
        end
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {1'b0, 5'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_wb: got rw=%b rd=%0d data=%h, want 0/0/0", regWriteOut, writeRegOut, writeDataOut);
        end
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++;
        if (alignErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alignerr: got %b, want 0", alignErr);
        end
`endif
        // Reset in the middle of an outstanding access.
        cyc();
        set_instr(32'h300, 32'h0, 5'd5, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_issue_stall: got %b, want 1", stall);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (memReq !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_req: got %b, want 1", memReq);
        end
        cyc();
        reset = 1'b1;
        nop();
        cyc();
        @(negedge clk);
        n_checks++;
        if ({memReq, regWriteOut, writeDataOut} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_abort: got req=%b rw=%b data=%h, want 0/0/0", memReq, regWriteOut, writeDataOut);
        end
        cyc();
        reset = 1'b0;
        cyc();
        memAck = 1'b1;
        memRData = 32'hBAD0BAD0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack_stall: got %b, want 0", stall);
        end
        cyc();
        memAck = 1'b0;
        memRData = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({memReq, regWriteOut, writeDataOut} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL late_ack_ignored: got req=%b rw=%b data=%h, want 0/0/0", memReq, regWriteOut, writeDataOut);
        end
        sb.delete();
    endtask

    task automatic test_alu();
        wb_t e;
        cyc();
        set_instr(32'h10, 32'h0, 5'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1'b1, 5'd8, 32'h10);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall: got %b, want 0", stall);
        end
        cyc();
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL alu_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL alu_next: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
    endtask

    task automatic test_load();
        wb_t e;
        int stalls;
        logic [31:0] a0, w0;
        logic we0;
        bit moved, bub, tmo;
        cyc();
        set_instr(32'h104, 32'h0, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_exp(1'b1, 5'd9, 32'hDEADBEEF);
        mem_txn(3, 32'hDEADBEEF, stalls, a0, we0, w0, moved, bub, tmo);
        n_checks++;
        if (tmo) begin
            n_fail++;
            $display("FAIL load_timeout: stall never dropped, stalls=%0d", stalls);
        end
        n_checks++;
        if (stalls !== 4) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d, want 4", stalls);
        end
        n_checks++;
        if ({a0, we0, moved, bub} !== {32'h104, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_req: got addr=%h we=%b moved=%b bubble_rw=%b, want 104/0/0/0", a0, we0, moved, bub);
        end
        cyc();
        memAck = 1'b0;
        memRData = 32'h0;
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL load_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        n_checks++;
        if (memReq !== 1'b0) begin
            n_fail++;
            $display("FAIL load_req_drop: got %b, want 0", memReq);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL load_one_cycle: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
    endtask

    task automatic test_store();
        wb_t e;
        int stalls;
        logic [31:0] a0, w0;
        logic we0;
        bit moved, bub, tmo;
        cyc();
        set_instr(32'h200, 32'h12345678, 5'd7, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(1'b0, 5'd7, 32'h200);
        mem_txn(1, 32'hFFFFFFFF, stalls, a0, we0, w0, moved, bub, tmo);
        n_checks++;
        if (tmo || stalls !== 2) begin
            n_fail++;
            $display("FAIL store_stall_cycles: got %0d timeout=%b, want 2", stalls, tmo);
        end
        n_checks++;
        if ({a0, we0, w0, bub} !== {32'h200, 1'b1, 32'h12345678, 1'b0}) begin
            n_fail++;
            $display("FAIL store_req: got addr=%h we=%b wdata=%h bubble_rw=%b, want 200/1/12345678/0", a0, we0, w0, bub);
        end
        cyc();
        memAck = 1'b0;
        memRData = 32'h0;
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL store_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
    endtask

    task automatic test_back_to_back();
        wb_t e;
        cyc();
        set_instr(32'h1234, 32'h0, 5'd31, 32'h00400008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(1'b1, 5'd31, 32'h00400008);
        cyc();
        set_instr(32'h55, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1'b0, 5'd0, 32'h55);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL jal_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall: got %b, want 0", stall);
        end
        cyc();
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL r0_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL b2b_nop_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
    endtask

    task automatic test_rw_violation();
        wb_t e;
        int stalls;
        logic [31:0] a0, w0;
        logic we0;
        bit moved, bub, tmo;
        cyc();
        set_instr(32'h40, 32'hA5A5A5A5, 5'd4, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1'b0, 5'd4, 32'h40);
        mem_txn(2, 32'h11111111, stalls, a0, we0, w0, moved, bub, tmo);
        n_checks++;
        if (tmo || stalls !== 3) begin
            n_fail++;
            $display("FAIL both_stall_cycles: got %0d timeout=%b, want 3", stalls, tmo);
        end
        n_checks++;
        if ({a0, we0, w0} !== {32'h40, 1'b1, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL both_req: got addr=%h we=%b wdata=%h, want 40/1/a5a5a5a5", a0, we0, w0);
        end
        cyc();
        memAck = 1'b0;
        memRData = 32'h0;
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL both_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        cyc();
        set_instr(32'h102, 32'h0, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL align_stall: got %b, want 0", stall);
        end
        cyc();
        nop();
        @(negedge clk);
        n_checks++;
        if ({memReq, alignErr, regWriteOut} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL align_err: got req=%b alignErr=%b rw=%b, want 0/1/0", memReq, alignErr, regWriteOut);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if ({memReq, alignErr} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL align_pulse: got req=%b alignErr=%b, want 0/0", memReq, alignErr);
        end
`else
        wb_t e;
        int stalls;
        logic [31:0] a0, w0;
        logic we0;
        bit moved, bub, tmo;
        cyc();
        set_instr(32'h102, 32'h0, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_exp(1'b1, 5'd9, 32'hCAFEF00D);
        mem_txn(1, 32'hCAFEF00D, stalls, a0, we0, w0, moved, bub, tmo);
        n_checks++;
        if (tmo || stalls !== 2 || a0 !== 32'h100) begin
            n_fail++;
            $display("FAIL unaligned_addr: got addr=%h stalls=%0d timeout=%b, want 100/2/0", a0, stalls, tmo);
        end
        cyc();
        memAck = 1'b0;
        memRData = 32'h0;
        nop();
        push_exp(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        pop_exp(e);
        n_checks++;
        if ({regWriteOut, writeRegOut, writeDataOut} !== {e.rw, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL unaligned_wb: got rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     regWriteOut, writeRegOut, writeDataOut, e.rw, e.rd, e.data);
        end
        cyc();
        @(negedge clk);
        pop_exp(e);
`endif
    endtask

    initial begin
        reset = 1'b1;
        memAck = 1'b0;
        memRData = 32'h0;
        nop();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_rw_violation();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
